// File: rtl/sysarr_pkg.sv
// Shared definitions for the systolic skew FIFO bank: drain FSM states,
// default geometry and the final-shift index helper.
package sysarr_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_DEPTH  = 4;
    localparam int unsigned DEF_ROWS   = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Counter value at which the final shift of a drain is accepted.
    function automatic int unsigned last_index(
        input int unsigned depth,
        input int unsigned rows,
        input int unsigned skew_en
    );
        return (skew_en != 0) ? (depth + rows - 2) : (depth - 1);
    endfunction

endpackage

// File: rtl/sysarr_fifo_row.sv
// One row channel: holds a loaded row of DEPTH elements and presents the
// element selected by the shared shift counter minus this row's skew offset.
//   clk, rst        clock, async active-high reset
//   i_load          capture i_data
//   i_data          DEPTH packed elements, element 0 in the MSBs
//   i_cnt           shared shift counter
//   i_drain         control FSM is draining
//   o_data_c        selected element, zero when not valid (combinational)
//   o_valid_c       element qualifier (combinational)
module sysarr_fifo_row
    import sysarr_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned CNT_W  = 3,
    parameter int unsigned OFFSET = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_load,
    input  logic [DEPTH*DATA_W-1:0] i_data,
    input  logic [CNT_W-1:0]        i_cnt,
    input  logic                    i_drain,
    output logic [DATA_W-1:0]       o_data_c,
    output logic                    o_valid_c
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [DEPTH*DATA_W-1:0] r_data;
    logic [DATA_W-1:0]       w_elem [DEPTH];
    logic [31:0]             w_k;
    logic                    w_in_window;
    logic [IDX_W-1:0]        w_idx;

    // Row data register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end
    end

    // Unpack elements; element 0 sits in the most significant slot.
    for (genvar e = 0; e < DEPTH; e++) begin : g_elem
        assign w_elem[e] = r_data[(DEPTH-1-e)*DATA_W +: DATA_W];
    end

    // Element index seen by this row; wraps huge when cnt < OFFSET.
    assign w_k         = 32'(i_cnt) - 32'(OFFSET);
    assign w_in_window = (32'(i_cnt) >= 32'(OFFSET)) && (w_k <= 32'(DEPTH - 1));
    assign w_idx       = IDX_W'(w_k);

    assign o_valid_c = i_drain && w_in_window;
    assign o_data_c  = o_valid_c ? w_elem[w_idx] : '0;

endmodule

// File: rtl/sysarr_skew_fifo_bank.sv
// Bank of ROWS row FIFOs feeding a systolic array. A load captures all rows
// and starts a drain; each shift advances a shared counter. With SKEW_EN
// row r lags row 0 by r shifts, otherwise all rows move in lockstep.
//   clk          clock, rising edge
//   RST          async active-high reset
//   load         capture load_values into every row, restart the drain
//   load_values  per-row packed elements, element 0 in the MSBs
//   shift        advance every row by one element (ignored when idle)
//   out          current element per row, zero when not valid
//   out_valid    per-row qualifier for out
//   busy         a load is being drained
//   overwrite    one-cycle pulse after a load accepted while busy
module sysarr_skew_fifo_bank
    import sysarr_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned ROWS    = DEF_ROWS,
    parameter int unsigned SKEW_EN = 1
) (
    input  logic                               clk,
    input  logic                               RST,
    input  logic                               load,
    input  logic [ROWS-1:0][DEPTH*DATA_W-1:0]  load_values,
    input  logic                               shift,
    output logic [ROWS-1:0][DATA_W-1:0]        out,
    output logic [ROWS-1:0]                    out_valid,
    output logic                               busy,
    output logic                               overwrite
);

    localparam int unsigned CNT_W = $clog2(DEPTH + ROWS);
    localparam int unsigned LAST  = last_index(DEPTH, ROWS, SKEW_EN);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic             r_overwrite;
    logic             w_next_overwrite;

    // Control state register.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_overwrite <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_next_cnt;
            r_overwrite <= w_next_overwrite;
        end
    end

    // Next-state logic; load wins over shift.
    always_comb begin
        w_next_state     = r_state;
        w_next_cnt       = r_cnt;
        w_next_overwrite = 1'b0;
        if (load) begin
            w_next_state     = DRAIN;
            w_next_cnt       = '0;
            w_next_overwrite = (r_state == DRAIN);
        end else if (shift && (r_state == DRAIN)) begin
            if (r_cnt == CNT_W'(LAST)) begin
                w_next_state = IDLE;
                w_next_cnt   = '0;
            end else begin
                w_next_cnt = r_cnt + CNT_W'(1);
            end
        end
    end

    assign busy      = (r_state == DRAIN);
    assign overwrite = r_overwrite;

    // One row channel per array row; skew offset fixed at elaboration.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        sysarr_fifo_row #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .CNT_W  (CNT_W),
            .OFFSET ((SKEW_EN != 0) ? r : 0)
        ) u_row (
            .clk       (clk),
            .rst       (RST),
            .i_load    (load),
            .i_data    (load_values[r]),
            .i_cnt     (r_cnt),
            .i_drain   (busy),
            .o_data_c  (out[r]),
            .o_valid_c (out_valid[r])
        );
    end

endmodule
